event_instruction_injector: RTL and testbench

Generalised hardware-event instruction builder for the CPU. It watches `NUM_CH` synchronous event lines and turns each rising edge into an `addi $rd, $0, imm` instruction, which it offers to the fetch/inject stage over a valid/ready handshake. Each channel writes its own destination register. Pending events are arbitrated round-robin. In COUNT mode, edges that arrive while an instruction is stalled are coalesced into one instruction whose immediate is the event count.

---
 rtl/inject_pkg.sv | 35 +++
 rtl/rr_arbiter.sv | 39 +++
 rtl/event_instruction_injector.sv | 154 +++++++++++++++
 tb/tb_event_instruction_injector.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/inject_pkg.sv
// Shared definitions for the event instruction injector.
//   - ADDI opcode and the bit positions of the 32-bit instruction fields
//   - Mode selectors (FLAG / COUNT)
//   - build_instr(): packs opcode, rd, rs and imm into one instruction word
package inject_pkg;

    localparam logic [4:0] OPC_ADDI = 5'd5;

    localparam int OPC_HI = 31;
    localparam int OPC_LO = 27;
    localparam int RD_HI  = 26;
    localparam int RD_LO  = 22;
    localparam int RS_HI  = 21;
    localparam int RS_LO  = 17;
    localparam int IMM_W  = 17;

    localparam int MODE_FLAG  = 0;
    localparam int MODE_COUNT = 1;

    function automatic logic [31:0] build_instr(
        input logic [4:0]       opc,
        input logic [4:0]       rd,
        input logic [4:0]       rs,
        input logic [IMM_W-1:0] imm
    );
        logic [31:0] word;
        word                = '0;
        word[OPC_HI:OPC_LO] = opc;
        word[RD_HI:RD_LO]   = rd;
        word[RS_HI:RS_LO]   = rs;
        word[IMM_W-1:0]     = imm;
        return word;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
//   req       : request vector, one bit per requester
//   last      : index of the most recently granted requester
//   gnt_valid : at least one request is present
//   gnt_idx   : first requesting index searching from last+1 (mod N) upward
module rr_arbiter #(
    parameter  int N  = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic          gnt_valid,
    output logic [IW-1:0] gnt_idx
);

    int            pos;
    logic [IW-1:0] idx;

    // Scan offsets from farthest to nearest so the nearest requester
    // after 'last' is the one written last and therefore wins.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        pos       = 0;
        idx       = '0;
        for (int i = N; i >= 1; i--) begin
            pos = int'(last) + i;
            if (pos >= N) begin
                pos = pos - N;
            end
            idx = IW'(pos);
            if (req[idx]) begin
                gnt_valid = 1'b1;
                gnt_idx   = idx;
            end
        end
    end

endmodule

// File: rtl/event_instruction_injector.sv
// Turns rising edges on NUM_CH event lines into "addi $rd, $0, imm"
// instructions offered over a valid/ready handshake.
//   clock, reset_n : clock (rising edge) and asynchronous active-low reset
//   event_in       : event levels, already synchronous to clock
//   inj_valid      : instruction holds a valid injection
//   inj_ready      : consumer accepts when inj_valid && inj_ready
//   instruction    : {opcode, rd, rs, imm}; all zero when inj_valid is low
//   pending        : channel counter is nonzero
//   overflow       : sticky, edge seen while the channel counter was full
module event_instruction_injector
    import inject_pkg::*;
#(
    parameter int NUM_CH    = 4,
    parameter int DEST_BASE = 24,
    parameter int MODE      = 0,
    parameter int CNT_W     = 4
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [NUM_CH-1:0] event_in,
    output logic              inj_valid,
    input  logic              inj_ready,
    output logic [31:0]       instruction,
    output logic [NUM_CH-1:0] pending,
    output logic [NUM_CH-1:0] overflow
);

    localparam int IW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [NUM_CH-1:0] prev_q, prev_d;
    logic [CNT_W-1:0]  cnt_q [NUM_CH];
    logic [CNT_W-1:0]  cnt_d [NUM_CH];
    logic [CNT_W-1:0]  snap_q, snap_d;
    logic [IW-1:0]     last_q, last_d;
    logic              valid_q, valid_d;
    logic [31:0]       instr_q, instr_d;
    logic [NUM_CH-1:0] ovf_q, ovf_d;

    logic [NUM_CH-1:0] edge_vec;
    logic [NUM_CH-1:0] pend_vec;
    logic              handshake;
    logic              gnt_valid;
    logic [IW-1:0]     gnt_idx;

    assign edge_vec  = event_in & ~prev_q;
    assign handshake = valid_q & inj_ready;
    assign prev_d    = event_in;

    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            pend_vec[c] = (cnt_q[c] != '0);
        end
    end

    // Counter update. The granted channel loses exactly the amount that was
    // reported (snap) on the handshake edge; edges arriving meanwhile are kept.
    logic [CNT_W-1:0] dec;
    logic [CNT_W-1:0] base;
    logic             keep;

    always_comb begin
        ovf_d = ovf_q;
        dec   = '0;
        base  = '0;
        keep  = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            dec = '0;
            if (handshake && (last_q == IW'(c))) begin
                dec = snap_q;
            end
            base     = cnt_q[c] - dec;
            cnt_d[c] = '0;
            if (MODE == MODE_COUNT) begin
                if ((base == '1) && edge_vec[c]) begin
                    cnt_d[c] = base;
                    ovf_d[c] = 1'b1;
                end else begin
                    cnt_d[c] = base + CNT_W'(edge_vec[c]);
                end
            end else begin
                keep        = cnt_q[c][0] & (dec == '0);
                cnt_d[c][0] = keep | edge_vec[c];
                if (keep && edge_vec[c]) begin
                    ovf_d[c] = 1'b1;
                end
            end
        end
    end

    rr_arbiter #(
        .N (NUM_CH)
    ) u_arb (
        .req       (pend_vec),
        .last      (last_q),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx)
    );

    // Load / hold / release of the offered instruction. Arbitration only runs
    // while nothing is offered, which leaves an idle cycle after each handshake.
    logic [IMM_W-1:0] imm;

    always_comb begin
        valid_d = valid_q;
        instr_d = instr_q;
        snap_d  = snap_q;
        last_d  = last_q;
        imm     = '0;
        if (handshake) begin
            valid_d = 1'b0;
            instr_d = '0;
        end else if (!valid_q && gnt_valid) begin
            valid_d = 1'b1;
            snap_d  = cnt_q[gnt_idx];
            last_d  = gnt_idx;
            if (MODE == MODE_COUNT) begin
                imm[CNT_W-1:0] = cnt_q[gnt_idx];
            end else begin
                imm = IMM_W'(1);
            end
            instr_d = build_instr(OPC_ADDI, 5'(DEST_BASE) + 5'(gnt_idx), 5'd0, imm);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            prev_q  <= '0;
            snap_q  <= '0;
            last_q  <= IW'(NUM_CH - 1);
            valid_q <= 1'b0;
            instr_q <= '0;
            ovf_q   <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                cnt_q[c] <= '0;
            end
        end else begin
            prev_q  <= prev_d;
            snap_q  <= snap_d;
            last_q  <= last_d;
            valid_q <= valid_d;
            instr_q <= instr_d;
            ovf_q   <= ovf_d;
            for (int c = 0; c < NUM_CH; c++) begin
                cnt_q[c] <= cnt_d[c];
            end
        end
    end

    assign inj_valid   = valid_q;
    assign instruction = instr_q;
    assign pending     = pend_vec;
    assign overflow    = ovf_q;

endmodule

// File: tb/tb_event_instruction_injector.sv
// Scoreboard bench: directed stimulus pushes expected instructions into a
// queue per instance; monitors pop and compare on every handshake.
module tb_event_instruction_injector;

    logic        clock;
    logic        reset_n;

    logic [3:0]  f_ev, f_pend, f_ovf;
    logic        f_ready, f_valid;
    logic [31:0] f_instr;

    logic [3:0]  c_ev, c_pend, c_ovf;
    logic        c_ready, c_valid;
    logic [31:0] c_instr;

    int checks = 0;
    int errors = 0;
    int f_hs   = 0;
    int c_hs   = 0;
    int hs0;

    logic [31:0] qf [$];
    logic [31:0] qc [$];

    event_instruction_injector #(
        .NUM_CH(4), .DEST_BASE(24), .MODE(0), .CNT_W(4)
    ) dut_f (
        .clock(clock), .reset_n(reset_n), .event_in(f_ev),
        .inj_valid(f_valid), .inj_ready(f_ready), .instruction(f_instr),
        .pending(f_pend), .overflow(f_ovf)
    );

    event_instruction_injector #(
        .NUM_CH(4), .DEST_BASE(24), .MODE(1), .CNT_W(2)
    ) dut_c (
        .clock(clock), .reset_n(reset_n), .event_in(c_ev),
        .inj_valid(c_valid), .inj_ready(c_ready), .instruction(c_instr),
        .pending(c_pend), .overflow(c_ovf)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    // Monitors
    logic        f_hold_v = 1'b0, f_hs_prev = 1'b0;
    logic [31:0] f_hold = '0;
    always @(negedge clock) begin
        if (!reset_n) begin
            f_hold_v  = 1'b0;
            f_hs_prev = 1'b0;
        end else begin
            if (f_hs_prev) chk("f idle after handshake", {31'd0, f_valid}, 32'd0);
            if (!f_valid) chk("f nop when idle", f_instr, 32'd0);
            if (f_valid && f_ready) begin
                f_hs++;
                if (qf.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL f unexpected injection: got %h expected none", f_instr);
                end else begin
                    chk("f injection", f_instr, qf.pop_front());
                end
            end
            if (f_valid && !f_ready) begin
                if (f_hold_v) chk("f stall stable", f_instr, f_hold);
                f_hold   = f_instr;
                f_hold_v = 1'b1;
            end else begin
                f_hold_v = 1'b0;
            end
            f_hs_prev = f_valid && f_ready;
        end
    end

    logic        c_hold_v = 1'b0, c_hs_prev = 1'b0;
    logic [31:0] c_hold = '0;
    always @(negedge clock) begin
        if (!reset_n) begin
            c_hold_v  = 1'b0;
            c_hs_prev = 1'b0;
        end else begin
            if (c_hs_prev) chk("c idle after handshake", {31'd0, c_valid}, 32'd0);
            if (!c_valid) chk("c nop when idle", c_instr, 32'd0);
            if (c_valid && c_ready) begin
                c_hs++;
                if (qc.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL c unexpected injection: got %h expected none", c_instr);
                end else begin
                    chk("c injection", c_instr, qc.pop_front());
                end
            end
            if (c_valid && !c_ready) begin
                if (c_hold_v) chk("c stall stable", c_instr, c_hold);
                c_hold   = c_instr;
                c_hold_v = 1'b1;
            end else begin
                c_hold_v = 1'b0;
            end
            c_hs_prev = c_valid && c_ready;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        reset_n = 1'b0;
        @(posedge clock); #1;
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n = 1'b0;
        f_ev = '0; c_ev = '0;
        f_ready = 1'b1; c_ready = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        chk("reset f valid",    {31'd0, f_valid}, 32'd0);
        chk("reset f instr",    f_instr, 32'd0);
        chk("reset f pending",  {28'd0, f_pend}, 32'd0);
        chk("reset c overflow", {28'd0, c_ovf}, 32'd0);
        reset_n = 1'b1;

        // FLAG single pulse on ch2
        qf.push_back(32'h2E80_0001);
        @(posedge clock); #1 f_ev = 4'b0100;
        @(posedge clock); #1 f_ev = 4'b0000;
        chk("t1 pending after E1", {28'd0, f_pend}, 32'h4);
        chk("t1 valid after E1",   {31'd0, f_valid}, 32'd0);
        @(posedge clock); #1;
        chk("t1 valid after E2",   {31'd0, f_valid}, 32'd1);
        chk("t1 instr after E2",   f_instr, 32'h2E80_0001);
        @(posedge clock); #1;
        chk("t1 valid after hs",   {31'd0, f_valid}, 32'd0);
        chk("t1 pending after hs", {28'd0, f_pend}, 32'd0);

        // Held level on ch0 counts once
        hs0 = f_hs;
        qf.push_back(32'h2E00_0001);
        @(posedge clock); #1 f_ev = 4'b0001;
        repeat (5) @(posedge clock);
        #1 f_ev = 4'b0000;
        repeat (6) @(posedge clock);
        #1;
        chk("t2 one injection", f_hs - hs0, 32'd1);
        chk("t2 pending clear", {28'd0, f_pend}, 32'd0);

        // Round-robin: 0,1,3 then ch3 ahead of ch0
        do_reset();
        qf.push_back(32'h2E00_0001);
        qf.push_back(32'h2E40_0001);
        qf.push_back(32'h2EC0_0001);
        qf.push_back(32'h2E00_0001);
        @(posedge clock); #1 f_ev = 4'b1011;
        @(posedge clock); #1 f_ev = 4'b0000;
        @(posedge clock);
        @(posedge clock);
        @(posedge clock); #1;
        chk("t3 ch1 granted", f_instr, 32'h2E40_0001);
        f_ev = 4'b1001;
        @(posedge clock); #1 f_ev = 4'b0000;
        repeat (10) @(posedge clock);
        #1;
        chk("t3 pending clear",  {28'd0, f_pend}, 32'd0);
        chk("t3 overflow ch3",   {28'd0, f_ovf}, 32'h8);
        chk("t3 all served",     32'(qf.size()), 32'd0);

        // COUNT coalescing on ch0 while stalled
        qc.push_back(32'h2E00_0001);
        qc.push_back(32'h2E00_0002);
        for (int k = 0; k < 3; k++) begin
            @(posedge clock); #1 c_ev = 4'b0001;
            @(posedge clock); #1 c_ev = 4'b0000;
        end
        @(posedge clock); #1;
        chk("t4 stalled valid", {31'd0, c_valid}, 32'd1);
        chk("t4 stalled instr", c_instr, 32'h2E00_0001);
        chk("t4 pending",       {28'd0, c_pend}, 32'h1);
        hs0 = c_hs;
        c_ready = 1'b1;
        repeat (6) @(posedge clock);
        #1;
        chk("t4 two injections", c_hs - hs0, 32'd2);
        chk("t4 pending clear",  {28'd0, c_pend}, 32'd0);
        c_ready = 1'b0;

        // Saturation: CNT_W=2, five pulses on ch1
        qc.push_back(32'h2E40_0001);
        qc.push_back(32'h2E40_0002);
        for (int k = 1; k <= 5; k++) begin
            @(posedge clock); #1 c_ev = 4'b0010;
            @(posedge clock); #1 c_ev = 4'b0000;
            chk($sformatf("t5 overflow after pulse %0d", k), {28'd0, c_ovf},
                (k >= 4) ? 32'h2 : 32'h0);
        end
        c_ready = 1'b1;
        repeat (6) @(posedge clock);
        #1;
        chk("t5 pending clear",    {28'd0, c_pend}, 32'd0);
        chk("t5 all served",       32'(qc.size()), 32'd0);
        c_ready = 1'b0;

        // Asynchronous reset during a stall
        @(posedge clock); #1 c_ev = 4'b0100;
        @(posedge clock); #1 c_ev = 4'b0000;
        for (int i = 0; i < 5; i++) begin
            if (c_valid) break;
            @(posedge clock); #1;
        end
        chk("t6 stalled before reset", {31'd0, c_valid}, 32'd1);
        @(posedge clock); #3 reset_n = 1'b0;
        #1;
        chk("t6 valid reset",    {31'd0, c_valid}, 32'd0);
        chk("t6 instr reset",    c_instr, 32'd0);
        chk("t6 pending reset",  {28'd0, c_pend}, 32'd0);
        chk("t6 overflow reset", {28'd0, c_ovf}, 32'd0);
        #10;
        @(posedge clock); #1 reset_n = 1'b1;
        qc.push_back(32'h2E00_0001);
        qc.push_back(32'h2EC0_0001);
        c_ready = 1'b1;
        @(posedge clock); #1 c_ev = 4'b1001;
        @(posedge clock); #1 c_ev = 4'b0000;
        repeat (8) @(posedge clock);
        #1;
        chk("t6 all served f", 32'(qf.size()), 32'd0);
        chk("t6 all served c", 32'(qc.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
